// File: rtl/oled_i2c_pkg.sv
`default_nettype none
// ============================================================================
// Package   : oled_i2c_pkg
// Purpose   : Shared types and constants for the I2C byte arbiter slice:
//             arbiter state encoding, default busy-guard length and the
//             SSD1306 D/C# values carried alongside each byte.
// Revision  : 1.0 - initial release
// ============================================================================
package oled_i2c_pkg;

  // Arbiter FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // no owner, arbitrating when the master is free
    ST_OWNED = 3'd1,  // owner holds the lock between bytes
    ST_ISSUE = 3'd2,  // one-cycle start/ack pulse
    ST_GUARD = 3'd3,  // waiting for i2c_busy to become meaningful
    ST_WAIT  = 3'd4   // waiting for the master to finish the byte
  } arb_state_e;

  // Cycles after the start pulse before the master's busy flag is trusted.
  localparam int BUSY_GUARD_DEF = 10;

  // SSD1306 D/C# encoding.
  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

endpackage : oled_i2c_pkg
`default_nettype wire

// File: rtl/i2c_byte_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module    : rr_pick
// Purpose   : Combinational round-robin priority encoder. Searches req_i
//             upward starting at ptr_i, wrapping past NREQ-1 to 0, and
//             returns the first requester found.
// Ports     : req_i    [NREQ]  request vector
//             ptr_i    [PW]    index with highest priority this round
//             winner_o [NREQ]  one-hot winner (all zero when none)
//             valid_o  [1]     a winner was found
// Revision  : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] winner_o,
  output logic            valid_o
);

  // Outer loop walks priority order (offset from the pointer); inner loop
  // keeps every bit index constant so the search unrolls into plain gates.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!valid_o && req_i[k] && (k == ((int'(ptr_i) + i) % NREQ))) begin
          winner_o[k] = 1'b1;
          valid_o     = 1'b1;
        end
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/i2c_byte_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : i2c_byte_arbiter
// Purpose   : Shares one i2c_master byte engine between NREQ requesters.
//             Round-robin arbitration, one byte per grant, with an optional
//             per-requester lock that keeps the grant across bytes so a
//             multi-byte sequence is never interleaved. A lock held with no
//             request is force-released after LOCK_TIMEOUT idle cycles.
// Ports     : clk, rst            clock, synchronous active-high reset
//             req_i      [NREQ]   byte request, held with data until ack
//             lock_i     [NREQ]   keep grant between bytes
//             req_dcn_i  [NREQ]   D/C# per requester
//             req_data_i [8*NREQ] byte per requester (k -> [8k+7:8k])
//             gnt_o      [NREQ]   one-hot current owner
//             ack_o      [NREQ]   byte captured (1-cycle)
//             done_o     [NREQ]   byte finished on the bus (1-cycle)
//             i2c_start_o         start pulse to i2c_master
//             i2c_dcn_o, i2c_data_o  byte presented to i2c_master
//             i2c_busy_i          busy flag from i2c_master
// Revision  : 1.0 - initial release
// ============================================================================
module i2c_byte_arbiter
  import oled_i2c_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int BUSY_GUARD   = BUSY_GUARD_DEF,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_i,
  input  logic [NREQ-1:0]     lock_i,
  input  logic [NREQ-1:0]     req_dcn_i,
  input  logic [8*NREQ-1:0]   req_data_i,
  output logic [NREQ-1:0]     gnt_o,
  output logic [NREQ-1:0]     ack_o,
  output logic [NREQ-1:0]     done_o,
  output logic                i2c_start_o,
  output logic                i2c_dcn_o,
  output logic [7:0]          i2c_data_o,
  input  logic                i2c_busy_i
);

  localparam int PW = $clog2(NREQ);
  // Guard counter only ever holds BUSY_GUARD-1 .. 0.
  localparam int GW = (BUSY_GUARD > 1) ? $clog2(BUSY_GUARD) : 1;
  // Idle counter releases when it would reach LOCK_TIMEOUT, so it tops out
  // at LOCK_TIMEOUT-1. With the timeout disabled it simply wraps.
  localparam int IW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [GW-1:0] GUARD_LOAD = GW'((BUSY_GUARD > 0) ? BUSY_GUARD - 1 : 0);
  localparam logic [IW-1:0] IDLE_LAST  = IW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  localparam logic [PW-1:0] PTR_LAST   = PW'(NREQ - 1);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [7:0]      data_q, data_d;
  logic            dcn_q, dcn_d;
  logic [GW-1:0]   guard_q, guard_d;
  logic [IW-1:0]   idle_q, idle_d;

  logic [NREQ-1:0] w_pick_winner;
  logic            w_pick_valid;
  logic [NREQ-1:0] w_cap_sel;
  logic [7:0]      w_sel_data;
  logic            w_sel_dcn;
  logic [PW-1:0]   w_owner_idx;
  logic [PW-1:0]   w_ptr_after;
  logic            w_owner_req;
  logic            w_owner_lock;
  logic            w_release;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .winner_o (w_pick_winner),
    .valid_o  (w_pick_valid)
  );

  // In IDLE the byte comes from the new winner; in OWNED from the owner.
  assign w_cap_sel = (state_q == ST_IDLE) ? w_pick_winner : gnt_q;

  always_comb begin
    w_sel_data = '0;
    w_sel_dcn  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_cap_sel[k]) begin
        w_sel_data = w_sel_data | req_data_i[8*k +: 8];
        w_sel_dcn  = w_sel_dcn  | req_dcn_i[k];
      end
    end
  end

  always_comb begin
    w_owner_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_q[k]) begin
        w_owner_idx = PW'(k);
      end
    end
  end

  // Next round starts just after the releasing owner.
  assign w_ptr_after  = (w_owner_idx == PTR_LAST) ? '0 : w_owner_idx + PW'(1);
  assign w_owner_req  = |(req_i & gnt_q);
  assign w_owner_lock = |(lock_i & gnt_q);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      dcn_q   <= DC_CMD;
      guard_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      dcn_q   <= dcn_d;
      guard_q <= guard_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    dcn_d     = dcn_q;
    guard_d   = guard_q;
    idle_d    = idle_q;
    w_release = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A byte may still be on the bus after a reset; wait it out.
        if (!i2c_busy_i && w_pick_valid) begin
          gnt_d   = w_pick_winner;
          data_d  = w_sel_data;
          dcn_d   = w_sel_dcn;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (BUSY_GUARD == 0) begin
          state_d = ST_WAIT;
        end else begin
          guard_d = GUARD_LOAD;
          state_d = ST_GUARD;
        end
      end

      ST_GUARD: begin
        // The master raises busy a few cycles after start; until then a low
        // busy does not mean the byte is finished.
        if (guard_q == '0) begin
          state_d = ST_WAIT;
        end else begin
          guard_d = guard_q - GW'(1);
        end
      end

      ST_WAIT: begin
        if (!i2c_busy_i) begin
          if (w_owner_lock) begin
            idle_d  = '0;
            state_d = ST_OWNED;
          end else begin
            w_release = 1'b1;
          end
        end
      end

      ST_OWNED: begin
        if (w_owner_req) begin
          data_d  = w_sel_data;
          dcn_d   = w_sel_dcn;
          state_d = ST_ISSUE;
        end else if (!w_owner_lock) begin
          w_release = 1'b1;
        end else if ((LOCK_TIMEOUT != 0) && (idle_q == IDLE_LAST)) begin
          w_release = 1'b1;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_release) begin
      gnt_d   = '0;
      ptr_d   = w_ptr_after;
      idle_d  = '0;
      state_d = ST_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign gnt_o       = gnt_q;
  assign i2c_start_o = (state_q == ST_ISSUE);
  assign ack_o       = (state_q == ST_ISSUE) ? gnt_q : '0;
  assign done_o      = ((state_q == ST_WAIT) && !i2c_busy_i) ? gnt_q : '0;
  assign i2c_data_o  = data_q;
  assign i2c_dcn_o   = dcn_q;

endmodule : i2c_byte_arbiter
`default_nettype wire

// File: tb/tb_i2c_byte_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : tb_i2c_byte_arbiter
// Purpose   : Self-checking bench for i2c_byte_arbiter. A stub master models
//             i2c_busy; a scoreboard queue holds the expected byte for each
//             ack in service order.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_i2c_byte_arbiter;
  import oled_i2c_pkg::*;

  localparam int NREQ = 2;
  localparam int BG   = 6;
  localparam int LT   = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ-1:0]     lock = '0;
  logic [NREQ-1:0]     req_dcn = '0;
  logic [8*NREQ-1:0]   req_data = '0;
  logic [NREQ-1:0]     gnt_o, ack_o, done_o;
  logic                i2c_start_o, i2c_dcn_o;
  logic [7:0]          i2c_data_o;
  logic                i2c_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  i2c_byte_arbiter #(
    .NREQ         (NREQ),
    .BUSY_GUARD   (BG),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .lock_i      (lock),
    .req_dcn_i   (req_dcn),
    .req_data_i  (req_data),
    .gnt_o       (gnt_o),
    .ack_o       (ack_o),
    .done_o      (done_o),
    .i2c_start_o (i2c_start_o),
    .i2c_dcn_o   (i2c_dcn_o),
    .i2c_data_o  (i2c_data_o),
    .i2c_busy_i  (i2c_busy)
  );

  // Stub master: busy rises the cycle after start and stays high for
  // bus_len cycles; bus_len=0 models a master that never reports busy.
  int   bus_len = 10;
  logic stub_busy = 1'b0;
  int   stub_cnt = 0;
  always @(posedge clk) begin
    if (i2c_start_o && bus_len > 0) begin
      stub_busy <= 1'b1;
      stub_cnt  <= bus_len;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_busy <= 1'b0;
    end
  end
  assign i2c_busy = stub_busy;

  // Scoreboard
  typedef struct packed {
    logic [NREQ-1:0] who;
    logic            dcn;
    logic [7:0]      data;
  } exp_t;
  exp_t sb_q[$];
  exp_t sb_e;

  initial begin
    forever begin
      @(negedge clk);
      if (ack_o !== '0) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_ack: got ack=%b, expected no ack", ack_o);
        end else begin
          sb_e = sb_q.pop_front();
          if (ack_o !== sb_e.who || i2c_data_o !== sb_e.data ||
              i2c_dcn_o !== sb_e.dcn || i2c_start_o !== 1'b1) begin
            bad++;
            $display("FAIL sb_byte: got ack=%b data=%h dcn=%b start=%b, expected ack=%b data=%h dcn=%b start=1",
                     ack_o, i2c_data_o, i2c_dcn_o, i2c_start_o, sb_e.who, sb_e.data, sb_e.dcn);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Expected done latency (negedges after the ack negedge).
  function automatic int done_lat(input int blen);
    return ((1 + BG) > (blen + 1)) ? (1 + BG) : (blen + 1);
  endfunction

  task automatic push_exp(input logic [NREQ-1:0] who, input logic dcn, input logic [7:0] data);
    exp_t e;
    e.who = who; e.dcn = dcn; e.data = data;
    sb_q.push_back(e);
  endtask

  // Bounded wait for a nonzero ack (which=0) or done (which=1).
  task automatic wait_sig(input int which, input int limit,
                          output logic [NREQ-1:0] seen, output int cycles);
    seen = '0;
    cycles = 0;
    while (cycles < limit) begin
      @(negedge clk);
      cycles++;
      seen = (which == 0) ? ack_o : done_o;
      if (seen !== '0) break;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; lock = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (gnt_o !== '0)        begin bad++; $display("FAIL rst_gnt: got %b expected 00", gnt_o); end
    total++; if (ack_o !== '0)        begin bad++; $display("FAIL rst_ack: got %b expected 00", ack_o); end
    total++; if (done_o !== '0)       begin bad++; $display("FAIL rst_done: got %b expected 00", done_o); end
    total++; if (i2c_start_o !== 1'b0) begin bad++; $display("FAIL rst_start: got %b expected 0", i2c_start_o); end
    total++; if (i2c_data_o !== 8'h00) begin bad++; $display("FAIL rst_data: got %h expected 00", i2c_data_o); end
    total++; if (i2c_dcn_o !== DC_CMD) begin bad++; $display("FAIL rst_dcn: got %b expected %b", i2c_dcn_o, DC_CMD); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (gnt_o !== '0 || i2c_start_o !== 1'b0) begin
      bad++; $display("FAIL idle_no_req: got gnt=%b start=%b expected 00/0", gnt_o, i2c_start_o);
    end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] s; int c;
    bus_len = 10;
    @(negedge clk);
    req[0] = 1'b1; req_dcn[0] = DC_CMD; req_data[7:0] = 8'hAE;
    push_exp(2'b01, DC_CMD, 8'hAE);
    wait_sig(0, 20, s, c);
    total++; if (s !== 2'b01 || c !== 1) begin bad++; $display("FAIL single_ack: got ack=%b after %0d cycles expected 01 after 1", s, c); end
    total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL single_gnt: got %b expected 01", gnt_o); end
    req[0] = 1'b0; req_data[7:0] = 8'h00;
    wait_sig(1, 60, s, c);
    total++; if (s !== 2'b01 || c !== done_lat(10)) begin bad++; $display("FAIL single_done: got done=%b after %0d expected 01 after %0d", s, c, done_lat(10)); end
    total++; if (i2c_data_o !== 8'hAE) begin bad++; $display("FAIL single_data_hold: got %h expected AE", i2c_data_o); end
    @(negedge clk);
    total++; if (gnt_o !== '0) begin bad++; $display("FAIL single_release: got gnt=%b expected 00", gnt_o); end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] s; int c;
    do_reset();
    req = 2'b11; req_dcn = 2'b10; req_data = {8'h22, 8'h11};
    push_exp(2'b01, 1'b0, 8'h11);
    push_exp(2'b10, 1'b1, 8'h22);
    push_exp(2'b01, 1'b0, 8'h33);
    wait_sig(0, 20, s, c);
    total++; if (s !== 2'b01) begin bad++; $display("FAIL cont_first: got ack=%b expected 01", s); end
    req_data[7:0] = 8'h33;               // requester 0 asks again immediately
    wait_sig(0, 60, s, c);
    total++; if (s !== 2'b10) begin bad++; $display("FAIL cont_second: got ack=%b expected 10", s); end
    req[1] = 1'b0;
    wait_sig(0, 60, s, c);
    total++; if (s !== 2'b01) begin bad++; $display("FAIL cont_third: got ack=%b expected 01", s); end
    req[0] = 1'b0;
    wait_sig(1, 60, s, c);
    total++; if (s !== 2'b01) begin bad++; $display("FAIL cont_done: got done=%b expected 01", s); end
  endtask

  task automatic test_lock_burst();
    logic [NREQ-1:0] s; int c;
    do_reset();
    lock[0] = 1'b1; req = 2'b11; req_dcn = 2'b10; req_data = {8'h55, 8'hB0};
    push_exp(2'b01, 1'b0, 8'hB0);
    push_exp(2'b01, 1'b0, 8'h00);
    push_exp(2'b01, 1'b0, 8'h10);
    push_exp(2'b10, 1'b1, 8'h55);
    wait_sig(0, 20, s, c);
    total++; if (s !== 2'b01) begin bad++; $display("FAIL lock_b0: got ack=%b expected 01", s); end
    req_data[7:0] = 8'h00;
    for (int b = 0; b < 2; b++) begin
      wait_sig(1, 60, s, c);
      total++; if (s !== 2'b01) begin bad++; $display("FAIL lock_done%0d: got done=%b expected 01", b, s); end
      wait_sig(0, 20, s, c);
      total++; if (s !== 2'b01 || c !== 2) begin bad++; $display("FAIL lock_b2b%0d: got ack=%b after %0d expected 01 after 2", b, s, c); end
      req_data[7:0] = 8'h10;
    end
    req[0] = 1'b0; lock[0] = 1'b0;
    wait_sig(1, 60, s, c);
    total++; if (s !== 2'b01) begin bad++; $display("FAIL lock_last_done: got done=%b expected 01", s); end
    wait_sig(0, 20, s, c);
    total++; if (s !== 2'b10 || c !== 2) begin bad++; $display("FAIL lock_handover: got ack=%b after %0d expected 10 after 2", s, c); end
    req[1] = 1'b0;
    wait_sig(1, 60, s, c);
    total++; if (s !== 2'b10) begin bad++; $display("FAIL lock_r1_done: got done=%b expected 10", s); end
  endtask

  task automatic test_lock_timeout();
    logic [NREQ-1:0] s; int c; int held; logic saw_done;
    do_reset();
    lock[0] = 1'b1; req = 2'b11; req_dcn = 2'b00; req_data = {8'h77, 8'h3C};
    push_exp(2'b01, 1'b0, 8'h3C);
    push_exp(2'b10, 1'b0, 8'h77);
    wait_sig(0, 20, s, c);
    req[0] = 1'b0;
    wait_sig(1, 60, s, c);
    total++; if (s !== 2'b01) begin bad++; $display("FAIL tmo_done: got done=%b expected 01", s); end
    held = 0; saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_o !== '0) saw_done = 1'b1;
      if (gnt_o !== 2'b01) break;
      held++;
    end
    total++; if (held !== LT) begin bad++; $display("FAIL tmo_hold: got %0d owned cycles expected %0d", held, LT); end
    total++; if (gnt_o !== '0) begin bad++; $display("FAIL tmo_release: got gnt=%b expected 00", gnt_o); end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL tmo_no_done: got done pulse=%b expected 0", saw_done); end
    wait_sig(0, 20, s, c);
    total++; if (s !== 2'b10 || c !== 1) begin bad++; $display("FAIL tmo_next: got ack=%b after %0d expected 10 after 1", s, c); end
    req[1] = 1'b0; lock[0] = 1'b0;
    wait_sig(1, 60, s, c);
  endtask

  task automatic test_reset_mid_byte();
    logic [NREQ-1:0] s; int c; int n; logic early;
    bus_len = 30;
    do_reset();
    req[0] = 1'b1; req_dcn[0] = 1'b1; req_data[7:0] = 8'hC3;
    push_exp(2'b01, 1'b1, 8'hC3);
    wait_sig(0, 20, s, c);
    req[0] = 1'b0;
    repeat (BG + 3) @(negedge clk);
    req[1] = 1'b1; req_dcn[1] = 1'b0; req_data[15:8] = 8'h99;
    push_exp(2'b10, 1'b0, 8'h99);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (gnt_o !== '0 || ack_o !== '0 || done_o !== '0 || i2c_start_o !== 1'b0 ||
        i2c_data_o !== 8'h00 || i2c_dcn_o !== 1'b0) begin
      bad++;
      $display("FAIL midrst_outputs: got gnt=%b ack=%b done=%b start=%b data=%h dcn=%b expected all zero",
               gnt_o, ack_o, done_o, i2c_start_o, i2c_data_o, i2c_dcn_o);
    end
    total++; if (i2c_busy !== 1'b1) begin bad++; $display("FAIL midrst_busy: got busy=%b expected 1", i2c_busy); end
    rst = 1'b0;
    early = 1'b0; n = 0;
    while (i2c_busy === 1'b1 && n < 80) begin
      if (i2c_start_o || ack_o !== '0 || done_o !== '0) early = 1'b1;
      @(negedge clk);
      n++;
    end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL midrst_early_start: got activity=%b expected 0", early); end
    total++; if (i2c_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy_fall: got busy=%b expected 0", i2c_busy); end
    wait_sig(0, 20, s, c);
    total++; if (s !== 2'b10 || c !== 1) begin bad++; $display("FAIL midrst_regrant: got ack=%b after %0d expected 10 after 1", s, c); end
    req[1] = 1'b0;
    wait_sig(1, 80, s, c);
    total++; if (s !== 2'b10) begin bad++; $display("FAIL midrst_done: got done=%b expected 10", s); end
  endtask

  task automatic test_busy_never();
    logic [NREQ-1:0] s; int c;
    bus_len = 0;
    @(negedge clk);
    req[0] = 1'b1; req_dcn[0] = DC_DATA; req_data[7:0] = 8'h5A;
    push_exp(2'b01, DC_DATA, 8'h5A);
    wait_sig(0, 20, s, c);
    req[0] = 1'b0;
    wait_sig(1, 40, s, c);
    total++; if (s !== 2'b01 || c !== done_lat(0)) begin bad++; $display("FAIL nobusy_done: got done=%b after %0d expected 01 after %0d", s, c, done_lat(0)); end
    @(negedge clk);
    total++; if (gnt_o !== '0) begin bad++; $display("FAIL nobusy_release: got gnt=%b expected 00", gnt_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lock_burst();
    test_lock_timeout();
    test_reset_mid_byte();
    test_busy_never();
    repeat (2) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d pending bytes expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_i2c_byte_arbiter
`default_nettype wire

// File: doc/i2c_byte_arbiter.md
Name: i2c_byte_arbiter

Overview:
- Shares the single i2c_master byte engine (start / DCn / Data / busy) between NREQ requesters, e.g. an SSD1306 init/framebuffer streamer and a sensor poller.
- Selects requesters round-robin and issues one byte per grant.
- Supports a lock, so that one requester's multi-byte sequence (page/column setup followed by 128 data bytes) is never interleaved with another requester's bytes.
- Sits between the requesters and i2c_master; it replaces the ad-hoc start/delay/busy polling inside each client.

Parameters:
- NREQ, 2, number of requesters (2..4).
- BUSY_GUARD, 10, clock cycles after the start pulse before i2c_busy is trusted.
- LOCK_TIMEOUT, 65535, idle cycles an owner may hold the lock with no req before it is force-released; 0 disables the timeout.

Ports:
- clk  in  1  system clock (24 MHz SB_HFOSC).
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester byte request; must be held with data/dcn until ack.
- lock  in  NREQ  per-requester hold; keeps the grant between bytes.
- req_dcn  in  NREQ  per-requester D/C# bit (0 = command, 1 = data).
- req_data  in  8*NREQ  per-requester byte; requester k uses bits [8k+7:8k].
- gnt  out  NREQ  one-hot current owner.
- ack  out  NREQ  1-cycle pulse: byte captured.
- done  out  NREQ  1-cycle pulse: byte finished on the bus.
- i2c_start  out  1  1-cycle start pulse to i2c_master.
- i2c_dcn  out  1  D/C# to i2c_master.
- i2c_data  out  8  byte to i2c_master.
- i2c_busy  in  1  busy flag from i2c_master.

Behaviour:
- Reset: gnt=0, ack=0, done=0, i2c_start=0, i2c_dcn=0, i2c_data=0, rr pointer=0, state=IDLE, counters=0.
- Reset mid-transfer does not abort the master's byte in flight. IDLE does not arbitrate while i2c_busy=1.
- States: IDLE, OWNED, ISSUE, GUARD, WAIT.
- IDLE:
  - If i2c_busy=0 and any req is high, pick the first requester with req high, searching upward from rr_ptr with wrap.
  - At that edge: set gnt to the winner, latch the winner's req_data/req_dcn into i2c_data/i2c_dcn, and go to ISSUE.
- ISSUE (1 cycle):
  - i2c_start=1 and ack[owner]=1, both in this cycle.
  - req sampled high at edge n therefore gives ack and i2c_start at cycle n+1.
  - Go to GUARD with guard_cnt=BUSY_GUARD-1.
- GUARD: decrement guard_cnt; at 0 go to WAIT. i2c_busy is ignored in this state.
- WAIT:
  - When i2c_busy=0: done[owner]=1 for 1 cycle.
  - If lock[owner]=1: go to OWNED and clear idle_cnt.
  - Otherwise: clear gnt, set rr_ptr=owner+1 (mod NREQ), go to IDLE.
- OWNED:
  - Only the owner's req is considered; other requesters' req/lock are ignored.
  - If req[owner]=1: latch its data, go to ISSUE.
  - Else if lock[owner]=0: release as in WAIT.
  - Else idle_cnt++. When idle_cnt reaches LOCK_TIMEOUT (if nonzero): release, no done pulse.
- i2c_data and i2c_dcn stay stable from capture until the next capture.
- Back-to-back: a requester streaming with lock held reaches ISSUE for the next byte 1 cycle after OWNED samples req. Minimum byte period is 3 + BUSY_GUARD cycles plus the bus time.
- Simultaneous events:
  - req and lock dropping together in OWNED: release wins.
  - All req low in IDLE: hold state; rr_ptr unchanged.
- A requester that drops req before ack is not an error: its request is lost only if still unsampled.
- Once captured, a byte always completes.

Decomposition:
- Package oled_i2c_pkg:
  - state enum.
  - BUSY_GUARD_DEF=10.
  - SSD1306 DC constants: DC_CMD=0, DC_DATA=1.
- Sub-module rr_pick: a combinational round-robin priority encoder. Inputs are req vector and rr_ptr; outputs are a one-hot winner and a valid flag.

Test Plan:
- Single request: req[0]=1, data 0xAE, dcn=0 → ack[0] and i2c_start 1 cycle later, i2c_data=0xAE. done[0] when i2c_busy falls after the guard; gnt returns to 0.
- Contention with rr_ptr=0: req=2'b11 → requester 0 served first, then requester 1 on the next grant. Repeat the same request pattern: requester 1 served first.
- Lock burst: requester 0 holds lock and sends 3 bytes (0xB0, 0x00, 0x10) while req[1] is high throughout → all 3 bytes go to requester 0 before any ack[1].
- Lock timeout with LOCK_TIMEOUT=8: owner holds lock with req low → gnt released after 8 idle cycles, with no done pulse; requester 1 is then granted.
- Reset mid-byte: rst during WAIT while i2c_busy=1 → outputs at reset values; no new i2c_start until i2c_busy=0.
- Busy never asserts (stub master): after ISSUE plus BUSY_GUARD cycles, done fires and the FSM does not hang.
